// File: rtl/traffic_light_fsm.sv
// Highway/farm-road traffic-light controller.
// Four-state Moore machine (HG, HY, FG, FY) timed by a tick-driven,
// saturating dwell counter. The farm request is registered once
// before use. The lights and the state-change strobe are registered.
module traffic_light_fsm #(
  parameter int CNT_W       = 4,
  parameter int GREEN_MIN   = 4,
  parameter int YELLOW_TIME = 2,
  parameter int FARM_MIN    = 1,
  parameter int FARM_MAX    = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       car_req,
  input  logic       tick,
  output logic [1:0] hwy_light,
  output logic [1:0] farm_light,
  output logic       state_chg
);

  typedef enum logic [1:0] {
    HG = 2'd0,
    HY = 2'd1,
    FG = 2'd2,
    FY = 2'd3
  } state_t;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GREEN_MIN_C = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] YELLOW_C    = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] FARM_MIN_C  = CNT_W'(FARM_MIN);
  localparam logic [CNT_W-1:0] FARM_MAX_C  = CNT_W'(FARM_MAX);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             req_r;
  logic             trans_s;
  logic [1:0]       hwy_r;
  logic [1:0]       farm_r;
  logic             chg_r;

  // Highway light code for a given state.
  function automatic logic [1:0] hwy_code(input state_t st);
    logic [1:0] code;
    case (st)
      HG:      code = LIGHT_GREEN;
      HY:      code = LIGHT_YELLOW;
      default: code = LIGHT_RED;
    endcase
    return code;
  endfunction

  // Farm light code for a given state.
  function automatic logic [1:0] farm_code(input state_t st);
    logic [1:0] code;
    case (st)
      FG:      code = LIGHT_GREEN;
      FY:      code = LIGHT_YELLOW;
      default: code = LIGHT_RED;
    endcase
    return code;
  endfunction

  // Next-state decision; evaluated every cycle regardless of tick.
  always_comb begin
    state_s = state_r;
    trans_s = 1'b0;
    case (state_r)
      HG: begin
        if (req_r && (cnt_r >= GREEN_MIN_C)) begin
          state_s = HY;
          trans_s = 1'b1;
        end else begin
          state_s = HG;
        end
      end
      HY: begin
        if (cnt_r >= YELLOW_C) begin
          state_s = FG;
          trans_s = 1'b1;
        end else begin
          state_s = HY;
        end
      end
      FG: begin
        if ((cnt_r >= FARM_MAX_C) || (!req_r && (cnt_r >= FARM_MIN_C))) begin
          state_s = FY;
          trans_s = 1'b1;
        end else begin
          state_s = FG;
        end
      end
      FY: begin
        if (cnt_r >= YELLOW_C) begin
          state_s = HG;
          trans_s = 1'b1;
        end else begin
          state_s = FY;
        end
      end
      default: begin
        state_s = HG;
        trans_s = 1'b1;
      end
    endcase
  end

  // State, request capture, registered lights and change strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= HG;
      req_r   <= 1'b0;
      hwy_r   <= LIGHT_GREEN;
      farm_r  <= LIGHT_RED;
      chg_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      req_r   <= car_req;
      hwy_r   <= hwy_code(state_s);
      farm_r  <= farm_code(state_s);
      chg_r   <= trans_s;
    end
  end

  // Dwell counter: cleared on a transition (tick lost), saturates at max.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (trans_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (tick && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hwy_light  = hwy_r;
  assign farm_light = farm_r;
  assign state_chg  = chg_r;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: a table-driven main
// sequence plus directed multi-cycle corner cases.
module tb_traffic_light_fsm;

  logic       clock;
  logic       reset;
  logic       car_req;
  logic       tick;
  logic [1:0] hwy_light;
  logic [1:0] farm_light;
  logic       state_chg;

  int checks;
  int failures;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  typedef struct {
    logic       rst;
    logic       req;
    logic       tk;
    logic [1:0] hwy;
    logic [1:0] farm;
    logic       chg;
  } vec_t;

  vec_t vecs[20];

  traffic_light_fsm dut (
    .clock      (clock),
    .reset      (reset),
    .car_req    (car_req),
    .tick       (tick),
    .hwy_light  (hwy_light),
    .farm_light (farm_light),
    .state_chg  (state_chg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string name, input logic [1:0] h, input logic [1:0] f, input logic c);
    check({name, ".hwy"}, {6'd0, hwy_light}, {6'd0, h});
    check({name, ".farm"}, {6'd0, farm_light}, {6'd0, f});
    check({name, ".chg"}, {7'd0, state_chg}, {7'd0, c});
  endtask

  task automatic do_reset(input logic req, input logic tk);
    reset = 1'b1;
    car_req = req;
    tick = tk;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    bit farm_green_seen;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    car_req = 1'b0;
    tick = 1'b0;

    // Main sequence with defaults, car_req=1 and tick=1 from before release.
    vecs[0]  = '{1'b0, 1'b1, 1'b1, G, R, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, G, R, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, G, R, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, G, R, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, Y, R, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, Y, R, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, Y, R, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, R, G, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, R, G, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, R, G, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, R, G, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, R, G, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, R, G, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, R, G, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, R, Y, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b1, R, Y, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, R, Y, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b1, G, R, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b1, G, R, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, G, R, 1'b0};

    // Reset, then idle hold with no request and no tick.
    do_reset(1'b0, 1'b0);
    check_out("reset", G, R, 1'b0);
    check("reset.cnt", {4'd0, dut.cnt_r}, 8'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check_out("idle", G, R, 1'b0);
    end

    // Full cycle from the table.
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      reset = vecs[i].rst;
      car_req = vecs[i].req;
      tick = vecs[i].tk;
      step();
      check_out($sformatf("cycle_e%0d", i + 1), vecs[i].hwy, vecs[i].farm, vecs[i].chg);
    end

    // No request for 40 ticks: stays HG, counter saturates.
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step();
      check_out("noreq", G, R, 1'b0);
    end
    check("noreq.cnt_sat", {4'd0, dut.cnt_r}, 8'd15);

    // Early farm release when the request drops.
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step();  // through E9: FG with cnt=1
    check_out("early.fg", R, G, 1'b0);
    car_req = 1'b0;
    step();                              // E10: req_q still 1
    check_out("early.e10", R, G, 1'b0);
    step();                              // E11
    check_out("early.fy", R, Y, 1'b1);
    farm_green_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (farm_light == G) farm_green_seen = 1'b1;
      check_out("early.fy_hold", R, Y, 1'b0);
    end
    step();                              // E14
    if (farm_light == G) farm_green_seen = 1'b1;
    check_out("early.hg", G, R, 1'b1);
    check("early.no_farm_green", {7'd0, farm_green_seen}, 8'd0);

    // Stall with tick low at cnt=2, then resume.
    do_reset(1'b0, 1'b1);
    step();
    step();
    check("stall.cnt2", {4'd0, dut.cnt_r}, 8'd2);
    tick = 1'b0;
    car_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_out("stall", G, R, 1'b0);
    end
    check("stall.cnt_frozen", {4'd0, dut.cnt_r}, 8'd2);
    tick = 1'b1;
    step();
    check_out("resume.r1", G, R, 1'b0);
    step();
    check_out("resume.r2", G, R, 1'b0);
    step();
    check_out("resume.r3", Y, R, 1'b1);

    // Reset mid-FY with cnt=1.
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step();
    check_out("midfy.pre", R, Y, 1'b0);
    check("midfy.cnt1", {4'd0, dut.cnt_r}, 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_out("midfy.rst", G, R, 1'b0);
    check("midfy.cnt0", {4'd0, dut.cnt_r}, 8'd0);

    // Reset on the same edge as the FY->HG transition.
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 17; i++) step();
    check_out("rsttr.pre", R, Y, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_out("rsttr.rst", G, R, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
